// File: rtl/nurse_pkg.sv
// Shared definitions for the ward call system (nurse station and ward caller).
//   state_t   : nurse-station FSM states
//   NUM_WARDS : number of ward call lines
//   *_DEF     : default timing terminal counts for a 100 MHz clock
//   prio_sel  : one-hot select of the lowest-index (highest-priority) set bit
package nurse_pkg;

    localparam int NUM_WARDS = 3;

    localparam logic [20:0] CNT_MAX_DEF   = 21'd1999999;  // 20 ms debounce
    localparam logic [24:0] BLINK_MAX_DEF = 25'd24999999; // 250 ms buzzer half-period
    localparam logic [26:0] ACK_HOLD_DEF  = 27'd99999999; // 1 s acknowledge lamp

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALERT = 2'b01,
        ACK   = 2'b10
    } state_t;

    // Isolates the lowest set bit: req & (two's complement of req).
    function automatic logic [NUM_WARDS-1:0] prio_sel(input logic [NUM_WARDS-1:0] req);
        return req & (~req + {{(NUM_WARDS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/nurse_station_responder_debounce.sv
// Single-bit debouncer.
//   clk  : system clock
//   rst  : synchronous active-high reset (dout -> 0)
//   din  : raw input
//   dout : debounced output; follows din only after din has differed from it
//          for CNT_MAX+1 consecutive cycles, any bounce back restarts the count
module nurse_debounce
    import nurse_pkg::*;
#(
    parameter logic [20:0] CNT_MAX = CNT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [20:0] cnt_reg;
    logic        dout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            dout_reg <= 1'b0;
        end else if (din != dout_reg) begin
            if (cnt_reg == CNT_MAX) begin
                dout_reg <= din;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 21'd1;
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/nurse_station_responder.sv
// Nurse-station responder: latches debounced ward calls into a sticky pending
// set, displays the highest-priority pending ward with a blinking buzzer, and
// on a debounced acknowledge clears that ward and pulses its acknowledge lamp.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   call     : raw ward call buttons, bit0 = ward 1 (highest priority)
//   ack      : raw nurse acknowledge button
//   led      : one-hot ward being served (000 = none)
//   ward_ack : one-hot acknowledge lamp back to the wards
//   buzzer   : toggles while a call is unanswered
//   busy     : any call pending or an acknowledge in progress
module nurse_station_responder
    import nurse_pkg::*;
#(
    parameter logic [20:0] CNT_MAX   = CNT_MAX_DEF,
    parameter logic [24:0] BLINK_MAX = BLINK_MAX_DEF,
    parameter logic [26:0] ACK_HOLD  = ACK_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WARDS-1:0] call,
    input  logic                 ack,
    output logic [NUM_WARDS-1:0] led,
    output logic [NUM_WARDS-1:0] ward_ack,
    output logic                 buzzer,
    output logic                 busy
);

    logic [NUM_WARDS-1:0] call_db;
    logic                 ack_db;

    generate
        for (genvar gi = 0; gi < NUM_WARDS; gi++) begin : g_call_db
            nurse_debounce #(.CNT_MAX(CNT_MAX)) u_db (
                .clk  (clk),
                .rst  (rst),
                .din  (call[gi]),
                .dout (call_db[gi])
            );
        end
    endgenerate

    nurse_debounce #(.CNT_MAX(CNT_MAX)) u_ack_db (
        .clk  (clk),
        .rst  (rst),
        .din  (ack),
        .dout (ack_db)
    );

    // Edges are registered, adding one stage between debounce and pending.
    logic [NUM_WARDS-1:0] call_db_q_reg, rise_reg;
    logic                 ack_db_q_reg, ack_rise_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            call_db_q_reg <= '0;
            rise_reg      <= '0;
            ack_db_q_reg  <= 1'b0;
            ack_rise_reg  <= 1'b0;
        end else begin
            call_db_q_reg <= call_db;
            rise_reg      <= call_db & ~call_db_q_reg;
            ack_db_q_reg  <= ack_db;
            ack_rise_reg  <= ack_db & ~ack_db_q_reg;
        end
    end

    state_t               state_reg, state_next;
    logic [NUM_WARDS-1:0] pending_reg, pending_next;
    logic [NUM_WARDS-1:0] cur_reg, cur_next;
    logic [NUM_WARDS-1:0] led_reg, led_next;
    logic [NUM_WARDS-1:0] ward_ack_reg, ward_ack_next;
    logic                 buzzer_reg, buzzer_next;
    logic                 busy_reg, busy_next;
    logic [24:0]          blink_reg, blink_next;
    logic [26:0]          hold_reg, hold_next;
    logic [NUM_WARDS-1:0] sel, clear;
    logic                 illegal;

    assign sel = prio_sel(pending_reg);

    always_comb begin
        state_next    = state_reg;
        clear         = '0;
        cur_next      = cur_reg;
        led_next      = '0;
        ward_ack_next = '0;
        buzzer_next   = 1'b0;
        blink_next    = '0;
        hold_next     = '0;
        illegal       = 1'b0;

        case (state_reg)
            IDLE: begin
                // clear is always zero here, so pending_next reduces to this.
                if ((pending_reg | rise_reg) != '0)
                    state_next = ALERT;
            end
            ALERT: begin
                if (ack_rise_reg) begin
                    clear         = sel;
                    cur_next      = sel;
                    ward_ack_next = sel;
                    state_next    = ACK;
                end else begin
                    led_next = sel;
                    if (blink_reg == BLINK_MAX) begin
                        buzzer_next = ~buzzer_reg;
                    end else begin
                        blink_next  = blink_reg + 25'd1;
                        buzzer_next = buzzer_reg;
                    end
                end
            end
            ACK: begin
                // Acknowledge presses are deliberately not observed here.
                if (hold_reg == ACK_HOLD) begin
                    state_next = (pending_reg != '0) ? ALERT : IDLE;
                end else begin
                    ward_ack_next = cur_reg;
                    hold_next     = hold_reg + 27'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cur_next   = '0;
                illegal    = 1'b1;
            end
        endcase

        // A rise on the ward being cleared wins, keeping it pending.
        pending_next = (pending_reg & ~clear) | rise_reg;
        busy_next    = !illegal && ((pending_next != '0) || (state_next == ACK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            cur_reg      <= '0;
            led_reg      <= '0;
            ward_ack_reg <= '0;
            buzzer_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            blink_reg    <= '0;
            hold_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            cur_reg      <= cur_next;
            led_reg      <= led_next;
            ward_ack_reg <= ward_ack_next;
            buzzer_reg   <= buzzer_next;
            busy_reg     <= busy_next;
            blink_reg    <= blink_next;
            hold_reg     <= hold_next;
        end
    end

    assign led      = led_reg;
    assign ward_ack = ward_ack_reg;
    assign buzzer   = buzzer_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_nurse_station_responder.sv
module tb_nurse_station_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] call;
    logic       ack;
    logic [2:0] led;
    logic [2:0] ward_ack;
    logic       buzzer;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nurse_station_responder #(
        .CNT_MAX   (21'd4),
        .BLINK_MAX (25'd3),
        .ACK_HOLD  (27'd7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .call     (call),
        .ack      (ack),
        .led      (led),
        .ward_ack (ward_ack),
        .buzzer   (buzzer),
        .busy     (busy)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic do_reset();
        call = 3'b000;
        ack  = 1'b0;
        rst  = 1'b1;
        step(2);
        rst  = 1'b0;
        step(1);
    endtask

    initial begin
        // Reset while all calls are held.
        rst  = 1'b1;
        call = 3'b111;
        ack  = 1'b0;
        step(3);
        chk("rst_led",      led,      8'h0);
        chk("rst_ward_ack", ward_ack, 8'h0);
        chk("rst_busy",     busy,     8'h0);
        chk("rst_buzzer",   buzzer,   8'h0);
        chk("rst_pending",  dut.pending_reg, 8'h0);
        call = 3'b000;
        step(1);
        rst = 1'b0;
        step(2);

        // Clean 111 press: pending after 7 edges, led after 8.
        call = 3'b111;
        step(7);
        chk("all_led_pre",  led,  8'h0);
        chk("all_pending",  dut.pending_reg, 8'h7);
        chk("all_busy",     busy, 8'h1);
        step(1);
        chk("all_led",      led,  8'h1);

        // Bounce on call[1]: 3-cycle pulses never register.
        do_reset();
        call = 3'b010; step(3);
        call = 3'b000; step(2);
        call = 3'b010; step(3);
        call = 3'b000; step(2);
        chk("bnc_pending0", dut.pending_reg, 8'h0);
        chk("bnc_led0",     led, 8'h0);
        call = 3'b010;
        step(7);
        chk("bnc_led_7",    led, 8'h0);
        step(1);
        chk("bnc_led_8",    led, 8'h2);
        chk("bnc_pending",  dut.pending_reg, 8'h2);
        step(2);

        // Preemption: ward 3 then ward 1.
        do_reset();
        call = 3'b100;
        step(8);
        chk("pre_led3",     led,    8'h4);
        chk("pre_buz_e8",   buzzer, 8'h0);
        step(2);
        chk("pre_buz_e10",  buzzer, 8'h0);
        step(1);
        chk("pre_buz_e11",  buzzer, 8'h1);
        step(3);
        chk("pre_buz_e14",  buzzer, 8'h1);
        step(1);
        chk("pre_buz_e15",  buzzer, 8'h0);
        call = 3'b101;
        step(7);
        chk("pre_led_old",  led, 8'h4);
        step(1);
        chk("pre_led1",     led, 8'h1);
        chk("pre_pending",  dut.pending_reg, 8'h5);

        // Acknowledge ward 1 while calls stay held.
        ack = 1'b1;
        step(6);
        chk("ack_wa_pre",   ward_ack, 8'h0);
        chk("ack_led_pre",  led,      8'h1);
        ack = 1'b0;
        step(1);
        chk("ack_wa",       ward_ack, 8'h1);
        chk("ack_led",      led,      8'h0);
        chk("ack_pending",  dut.pending_reg, 8'h4);
        chk("ack_busy",     busy,     8'h1);
        step(4);
        ack = 1'b1;          // short second press during the hold
        step(2);
        ack = 1'b0;
        chk("ack_wa_mid",   ward_ack, 8'h1);
        chk("ack_led_mid",  led,      8'h0);
        step(1);
        chk("ack_wa_last",  ward_ack, 8'h1);
        step(1);
        chk("ack_wa_end",   ward_ack, 8'h0);
        chk("ack_led_end",  led,      8'h0);
        step(1);
        chk("ack_led_next", led,      8'h4);
        chk("ack_buz_rst",  buzzer,   8'h0);
        step(2);
        chk("ack_buz_e18",  buzzer,   8'h0);
        step(1);
        chk("ack_buz_e19",  buzzer,   8'h1);
        step(5);
        chk("held_pending", dut.pending_reg, 8'h4);
        chk("held_led",     led,      8'h4);
        chk("held_wa",      ward_ack, 8'h0);

        // Acknowledge coincides with a re-press rise on ward 1.
        do_reset();
        call = 3'b001;
        step(8);
        chk("sim_led1",     led, 8'h1);
        call = 3'b000;
        step(7);
        call = 3'b001;
        ack  = 1'b1;
        step(7);
        chk("sim_wa",       ward_ack, 8'h1);
        chk("sim_pending",  dut.pending_reg, 8'h1);
        chk("sim_led0",     led, 8'h0);
        ack = 1'b0;
        step(8);
        chk("sim_wa_end",   ward_ack, 8'h0);
        step(1);
        chk("sim_led_back", led,  8'h1);
        chk("sim_busy",     busy, 8'h1);

        // Reset in the middle of an acknowledge.
        step(6);
        ack = 1'b1;
        step(7);
        chk("mid_wa",       ward_ack, 8'h1);
        step(2);
        rst  = 1'b1;
        call = 3'b000;
        ack  = 1'b0;
        step(1);
        chk("mid_led",      led,      8'h0);
        chk("mid_wa0",      ward_ack, 8'h0);
        chk("mid_buzzer",   buzzer,   8'h0);
        chk("mid_busy",     busy,     8'h0);
        chk("mid_pending",  dut.pending_reg, 8'h0);
        rst = 1'b0;
        step(3);
        chk("mid_idle_led", led,  8'h0);
        chk("mid_idle_bsy", busy, 8'h0);
        call = 3'b001;
        step(8);
        chk("mid_repress",  led,  8'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
